// File: rtl/fifo_param_pkg.sv
// Shared helpers for the parametrised single-clock FIFO: width helpers,
// reset constants and the grouped status flag type.
// Build option: FIFO_FWFT_EN selects first-word-fall-through output mode.
package fifo_param_pkg;

    // Ceiling log2, usable in constant expressions
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Address bits needed to index a memory of the given depth
    function automatic int addr_w(input int depth);
        return clog2(depth);
    endfunction

    // Occupancy counter width: must represent 0..depth inclusive
    function automatic int cnt_w(input int depth);
        return clog2(depth) + 1;
    endfunction

    // Widths for the default 8-entry configuration
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_ADDR_W = addr_w(DEF_DEPTH);
    localparam int DEF_CNT_W  = cnt_w(DEF_DEPTH);

    // All registered status flags travel together
    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    // An empty FIFO is also almost-empty; everything else is clear
    localparam fifo_status_t STATUS_RESET = '{
        empty:        1'b1,
        full:         1'b0,
        almost_empty: 1'b1,
        almost_full:  1'b0,
        overflow:     1'b0,
        underflow:    1'b0
    };

endpackage

// File: rtl/fifo_param_mem.sv
// Simple dual-port DATA_W x DEPTH storage array for fifo_param.
// One write port, one registered read port. The array itself is never
// reset; only the read register is cleared so the FIFO output starts at 0.
module fifo_param_mem
    import fifo_param_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [addr_w(DEPTH)-1:0]  wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      rd_en,
    input  logic [addr_w(DEPTH)-1:0]  rd_addr,
    output logic [DATA_W-1:0]         rd_data
);

    logic [DATA_W-1:0] mem_array [DEPTH];
    logic [DATA_W-1:0] rd_data_reg;

    // Write port: store the incoming word at the write address
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_array[wr_addr] <= wr_data;
        end
    end

    // Registered read port: loads only on request, otherwise holds.
    // A read and write to the same address on one edge returns the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem_array[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous single-clock FIFO with occupancy count,
// almost-full/almost-empty thresholds, global enable and overflow/underflow
// pulses. Pointers carry an extra wrap bit so full and empty are distinct.
// Build option: define FIFO_FWFT_EN for first-word-fall-through output;
// otherwise dataOut is a registered read, valid one cycle after RD.
module fifo_param
    import fifo_param_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     EN,
    input  logic                     WR,
    input  logic [DATA_W-1:0]        dataIn,
    input  logic                     RD,
    output logic [DATA_W-1:0]        dataOut,
    output logic                     EMPTY,
    output logic                     FULL,
    output logic                     ALMOST_EMPTY,
    output logic                     ALMOST_FULL,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     OVERFLOW,
    output logic                     UNDERFLOW
);

    localparam int ADDR_W = addr_w(DEPTH);
    localparam int CNT_W  = cnt_w(DEPTH);

    localparam logic [CNT_W-1:0] AF_C  = CNT_W'(AF_LVL);
    localparam logic [CNT_W-1:0] AE_C  = CNT_W'(AE_LVL);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    logic [ADDR_W:0]    wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W:0]    rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    fifo_status_t       status_reg, status_next;
    logic               wr_acc, rd_acc;
    logic               mem_rd_en;
    logic [ADDR_W-1:0]  mem_rd_addr;
    logic [DATA_W-1:0]  mem_q;

    // Accept decisions, next pointers, next count and next status flags.
    // Flags are derived from the next-state values so they line up with COUNT.
    always_comb begin
        rd_acc = EN & RD & ~status_reg.empty;
        // A full FIFO still takes a write when a read frees a slot this edge
        wr_acc = EN & WR & (~status_reg.full | rd_acc);

        wr_ptr_next = wr_acc ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
        rd_ptr_next = rd_acc ? rd_ptr_reg + 1'b1 : rd_ptr_reg;

        count_next = count_reg;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase

        status_next              = STATUS_RESET;
        status_next.empty        = (wr_ptr_next == rd_ptr_next);
        status_next.full         = (wr_ptr_next[ADDR_W-1:0] == rd_ptr_next[ADDR_W-1:0]) &&
                                   (wr_ptr_next[ADDR_W] != rd_ptr_next[ADDR_W]);
        status_next.almost_empty = (count_next <= AE_C);
        status_next.almost_full  = (count_next >= AF_C);
        status_next.overflow     = EN & WR & ~wr_acc;
        status_next.underflow    = EN & RD & ~rd_acc;
    end

    // Control state: pointers, occupancy and registered flags
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            status_reg <= STATUS_RESET;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            status_reg <= status_next;
        end
    end

`ifdef FIFO_FWFT_EN
    // Look-ahead head register. A word entering an otherwise empty FIFO
    // (including the refill when the last word is popped on the same edge)
    // is captured straight from dataIn; every other new head is already in
    // the array and is fetched at rd_ptr+1 on the popping edge.
    logic              load_byp;
    logic              byp_sel_reg;
    logic [DATA_W-1:0] byp_data_reg;

    assign load_byp    = wr_acc & (status_reg.empty | (rd_acc & (count_reg == ONE_C)));
    assign mem_rd_en   = rd_acc & (count_reg > ONE_C);
    assign mem_rd_addr = rd_ptr_next[ADDR_W-1:0];

    // Select between the bypass word and the array read; hold when idle
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            byp_sel_reg  <= 1'b0;
            byp_data_reg <= '0;
        end else if (load_byp) begin
            byp_sel_reg  <= 1'b1;
            byp_data_reg <= dataIn;
        end else if (mem_rd_en) begin
            byp_sel_reg  <= 1'b0;
        end
    end

    assign dataOut = byp_sel_reg ? byp_data_reg : mem_q;
`else
    // Registered read: the popped word appears one cycle after RD
    assign mem_rd_en   = rd_acc;
    assign mem_rd_addr = rd_ptr_reg[ADDR_W-1:0];
    assign dataOut     = mem_q;
`endif

    fifo_param_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (Clk),
        .rst_n   (Rst),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_reg[ADDR_W-1:0]),
        .wr_data (dataIn),
        .rd_en   (mem_rd_en),
        .rd_addr (mem_rd_addr),
        .rd_data (mem_q)
    );

    assign COUNT        = count_reg;
    assign EMPTY        = status_reg.empty;
    assign FULL         = status_reg.full;
    assign ALMOST_EMPTY = status_reg.almost_empty;
    assign ALMOST_FULL  = status_reg.almost_full;
    assign OVERFLOW     = status_reg.overflow;
    assign UNDERFLOW    = status_reg.underflow;

endmodule

// File: tb/tb_fifo_param.sv
// Directed, table-driven bench for fifo_param (DATA_W=32, DEPTH=8,
// AF_LVL=6, AE_LVL=2). Define FIFO_FWFT_EN to exercise the look-ahead mode.
module tb_fifo_param;

    logic        Clk;
    logic        Rst;
    logic        EN;
    logic        WR;
    logic [31:0] dataIn;
    logic        RD;
    logic [31:0] dataOut;
    logic        EMPTY;
    logic        FULL;
    logic        ALMOST_EMPTY;
    logic        ALMOST_FULL;
    logic [3:0]  COUNT;
    logic        OVERFLOW;
    logic        UNDERFLOW;

    int n_pass  = 0;
    int n_total = 0;

    fifo_param #(
        .DATA_W (32),
        .DEPTH  (8),
        .AF_LVL (6),
        .AE_LVL (2)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .EN           (EN),
        .WR           (WR),
        .dataIn       (dataIn),
        .RD           (RD),
        .dataOut      (dataOut),
        .EMPTY        (EMPTY),
        .FULL         (FULL),
        .ALMOST_EMPTY (ALMOST_EMPTY),
        .ALMOST_FULL  (ALMOST_FULL),
        .COUNT        (COUNT),
        .OVERFLOW     (OVERFLOW),
        .UNDERFLOW    (UNDERFLOW)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        logic        en;
        logic        wr;
        logic        rd;
        logic [31:0] din;
        int          cnt;
        logic        emp;
        logic        ful;
        logic        ae;
        logic        af;
        logic        ov;
        logic        un;
        logic [31:0] dout;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, sample 1ns later
    task automatic step(input logic en, input logic wr, input logic rd, input logic [31:0] din);
        EN = en; WR = wr; RD = rd; dataIn = din;
        @(posedge Clk);
        #1;
        $display("t=%0t en=%0b wr=%0b rd=%0b din=0x%0h -> count=%0d dout=0x%0h e=%0b f=%0b ae=%0b af=%0b ov=%0b un=%0b",
                 $time, en, wr, rd, din, COUNT, dataOut, EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL,
                 OVERFLOW, UNDERFLOW);
    endtask

    task automatic push(input logic en, input logic wr, input logic rd, input logic [31:0] din,
                        input int cnt, input logic emp, input logic ful, input logic ae,
                        input logic af, input logic ov, input logic un, input logic [31:0] dout);
        vec_t v;
        v.en = en; v.wr = wr; v.rd = rd; v.din = din;
        v.cnt = cnt; v.emp = emp; v.ful = ful; v.ae = ae; v.af = af;
        v.ov = ov; v.un = un; v.dout = dout;
        vecs.push_back(v);
    endtask

    initial begin
        Rst = 1'b1; EN = 1'b0; WR = 1'b0; RD = 1'b0; dataIn = '0;

        // Reset with requests active must still leave a clean empty FIFO
        #2;
        Rst = 1'b0; EN = 1'b1; WR = 1'b1; RD = 1'b1; dataIn = 32'h99;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_empty", 32'(EMPTY), 32'd1);
        check("rst_full", 32'(FULL), 32'd0);
        check("rst_count", 32'(COUNT), 32'd0);
        check("rst_dout", dataOut, 32'd0);
        check("rst_ae", 32'(ALMOST_EMPTY), 32'd1);
        check("rst_af", 32'(ALMOST_FULL), 32'd0);
        check("rst_ov", 32'(OVERFLOW), 32'd0);
        check("rst_un", 32'(UNDERFLOW), 32'd0);
        EN = 1'b0; WR = 1'b0; RD = 1'b0;
        Rst = 1'b1;

`ifdef FIFO_FWFT_EN
        // Look-ahead: a write into empty shows without RD; pops advance the head
        step(1, 1, 0, 32'h55);
        check("fwft_wr_empty_dout", dataOut, 32'h55);
        check("fwft_wr_empty_e", 32'(EMPTY), 32'd0);
        step(1, 0, 0, 32'h0);
        check("fwft_idle_dout", dataOut, 32'h55);
        step(1, 1, 0, 32'h66);
        check("fwft_second_dout", dataOut, 32'h55);
        check("fwft_second_cnt", 32'(COUNT), 32'd2);
        step(1, 0, 1, 32'h0);
        check("fwft_pop_dout", dataOut, 32'h66);
        check("fwft_pop_cnt", 32'(COUNT), 32'd1);
        step(1, 0, 1, 32'h0);
        check("fwft_last_hold", dataOut, 32'h66);
        check("fwft_last_e", 32'(EMPTY), 32'd1);
        step(1, 1, 0, 32'h77);
        check("fwft_w77", dataOut, 32'h77);
        step(1, 1, 1, 32'h88);
        check("fwft_rw_one_dout", dataOut, 32'h88);
        check("fwft_rw_one_cnt", 32'(COUNT), 32'd1);
        step(1, 0, 1, 32'h0);
        check("fwft_drain_hold", dataOut, 32'h88);
        check("fwft_drain_cnt", 32'(COUNT), 32'd0);
`else
        // Fill 1..8: ALMOST_FULL from 6, FULL at 8, dataOut untouched
        for (int i = 1; i <= 8; i++) begin
            push(1, 1, 0, 32'(i), i, 0, (i == 8), (i <= 2), (i >= 6), 0, 0, 32'h0);
        end
        // Write into full: rejected, one-cycle OVERFLOW
        push(1, 1, 0, 32'h9, 8, 0, 1, 0, 1, 1, 0, 32'h0);
        push(1, 0, 0, 32'h0, 8, 0, 1, 0, 1, 0, 0, 32'h0);
        // Full with RD&WR: both accepted, still full, no OVERFLOW
        push(1, 1, 1, 32'hA, 8, 0, 1, 0, 1, 0, 0, 32'h1);
        // Drain: 2..8 then 0xA; 9 never appears
        push(1, 0, 1, 32'h0, 7, 0, 0, 0, 1, 0, 0, 32'h2);
        push(1, 0, 1, 32'h0, 6, 0, 0, 0, 1, 0, 0, 32'h3);
        push(1, 0, 1, 32'h0, 5, 0, 0, 0, 0, 0, 0, 32'h4);
        push(1, 0, 1, 32'h0, 4, 0, 0, 0, 0, 0, 0, 32'h5);
        push(1, 0, 1, 32'h0, 3, 0, 0, 0, 0, 0, 0, 32'h6);
        push(1, 0, 1, 32'h0, 2, 0, 0, 1, 0, 0, 0, 32'h7);
        push(1, 0, 1, 32'h0, 1, 0, 0, 1, 0, 0, 0, 32'h8);
        push(1, 0, 1, 32'h0, 0, 1, 0, 1, 0, 0, 0, 32'hA);
        // Read from empty: UNDERFLOW, dataOut holds
        push(1, 0, 1, 32'h0, 0, 1, 0, 1, 0, 0, 1, 32'hA);
        // Empty with RD&WR: write only, read rejected
        push(1, 1, 1, 32'hB, 1, 0, 0, 1, 0, 0, 1, 32'hA);
        push(1, 0, 1, 32'h0, 0, 1, 0, 1, 0, 0, 0, 32'hB);
        // Disabled: requests ignored, no pulses
        push(0, 1, 0, 32'h77, 0, 1, 0, 1, 0, 0, 0, 32'hB);
        push(0, 0, 1, 32'h0, 0, 1, 0, 1, 0, 0, 0, 32'hB);

        foreach (vecs[k]) begin
            step(vecs[k].en, vecs[k].wr, vecs[k].rd, vecs[k].din);
            check($sformatf("v%0d_count", k), 32'(COUNT), 32'(vecs[k].cnt));
            check($sformatf("v%0d_empty", k), 32'(EMPTY), 32'(vecs[k].emp));
            check($sformatf("v%0d_full", k), 32'(FULL), 32'(vecs[k].ful));
            check($sformatf("v%0d_ae", k), 32'(ALMOST_EMPTY), 32'(vecs[k].ae));
            check($sformatf("v%0d_af", k), 32'(ALMOST_FULL), 32'(vecs[k].af));
            check($sformatf("v%0d_ov", k), 32'(OVERFLOW), 32'(vecs[k].ov));
            check($sformatf("v%0d_un", k), 32'(UNDERFLOW), 32'(vecs[k].un));
            check($sformatf("v%0d_dout", k), dataOut, vecs[k].dout);
        end
`endif

        // 20 write/read pairs: pointers wrap twice, order must be preserved
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 0, 32'(32'h10 + i));
            check($sformatf("wrap%0d_cnt_w", i), 32'(COUNT), 32'd1);
            step(1, 0, 1, 32'h0);
            check($sformatf("wrap%0d_dout", i), dataOut, 32'(32'h10 + i));
            check($sformatf("wrap%0d_cnt_r", i), 32'(COUNT), 32'd0);
        end

        // Reset mid-operation clears state without waiting for a clock edge
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0, 32'(32'h30 + i));
        end
        check("mid_count5", 32'(COUNT), 32'd5);
        EN = 1'b0; WR = 1'b0; RD = 1'b0;
        #2;
        Rst = 1'b0;
        #1;
        check("mid_rst_count", 32'(COUNT), 32'd0);
        check("mid_rst_empty", 32'(EMPTY), 32'd1);
        check("mid_rst_dout", dataOut, 32'd0);
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        step(1, 1, 0, 32'h40);
        step(1, 0, 1, 32'h0);
        check("post_rst_dout", dataOut, 32'h40);
        check("post_rst_count", 32'(COUNT), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
